// File: rtl/rc_vc_stage.sv
// Per-VC route computation stage (XY/YX dimension-order) with packet route hold.
// Optional RC_DEST_CHECK_EN: out-of-mesh destinations route LOCAL and pulse dest_err_o.
// Port encoding: LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4.
module rc_vc_stage #(
  parameter int X_CURRENT        = 0,
  parameter int Y_CURRENT        = 0,
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4,
  parameter int VC_NUM           = 2,
  parameter int ROUTING_MODE     = 0,
  parameter int MESH_SIZE_X      = 4,
  parameter int MESH_SIZE_Y      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_i,
  input  logic [$clog2(VC_NUM)-1:0]       vc_id_i,
  input  logic                            head_i,
  input  logic                            tail_i,
  input  logic [DEST_ADDR_SIZE_X-1:0]     x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0]     y_dest_i,
  output logic [VC_NUM-1:0][2:0]          out_port_o,
  output logic [VC_NUM-1:0]               route_valid_o,
  output logic                            proto_err_o
`ifdef RC_DEST_CHECK_EN
  ,
  output logic                            dest_err_o
`endif
);

  localparam int VCW = $clog2(VC_NUM);
  localparam int DXW = DEST_ADDR_SIZE_X + 1;
  localparam int DYW = DEST_ADDR_SIZE_Y + 1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_SOUTH = 3'd2;
  localparam logic [2:0] P_WEST  = 3'd3;
  localparam logic [2:0] P_EAST  = 3'd4;

  if (VC_NUM < 2 || MESH_SIZE_X < 1 || MESH_SIZE_Y < 1) begin : g_bad_cfg
    $error("rc_vc_stage: invalid configuration");
  end

  typedef enum logic [1:0] {IDLE, ROUTED, LAST} vc_state_t;

  vc_state_t        state [VC_NUM];
  logic [DXW-1:0]   dx;
  logic [DYW-1:0]   dy;
  logic             x_neg, x_pos, y_neg, y_pos;
  logic [2:0]       route_c;
  logic [2:0]       route_l;
  logic             vc_ok;

  // Two's-complement offsets one bit wider than the field; MSB is the sign.
  always_comb begin
    dx    = {1'b0, x_dest_i} - DXW'(X_CURRENT);
    dy    = {1'b0, y_dest_i} - DYW'(Y_CURRENT);
    x_neg = dx[DXW-1];
    y_neg = dy[DYW-1];
    x_pos = !x_neg && (dx != '0);
    y_pos = !y_neg && (dy != '0);
    route_c = P_LOCAL;
    if (ROUTING_MODE == 0) begin
      if (x_neg)      route_c = P_WEST;
      else if (x_pos) route_c = P_EAST;
      else if (y_neg) route_c = P_NORTH;
      else if (y_pos) route_c = P_SOUTH;
    end else begin
      if (y_neg)      route_c = P_NORTH;
      else if (y_pos) route_c = P_SOUTH;
      else if (x_neg) route_c = P_WEST;
      else if (x_pos) route_c = P_EAST;
    end
  end

`ifdef RC_DEST_CHECK_EN
  logic dest_oor;
  assign dest_oor = (32'(x_dest_i) >= MESH_SIZE_X) || (32'(y_dest_i) >= MESH_SIZE_Y);
  assign route_l  = dest_oor ? P_LOCAL : route_c;
`else
  assign route_l  = route_c;
`endif

  assign vc_ok = (32'(vc_id_i) < VC_NUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state[v]         <= IDLE;
        out_port_o[v]    <= P_LOCAL;
        route_valid_o[v] <= 1'b0;
      end
      proto_err_o <= 1'b0;
`ifdef RC_DEST_CHECK_EN
      dest_err_o  <= 1'b0;
`endif
    end else begin
      proto_err_o <= valid_i && !vc_ok;
`ifdef RC_DEST_CHECK_EN
      dest_err_o  <= 1'b0;
`endif
      for (int v = 0; v < VC_NUM; v++) begin
        if (valid_i && vc_ok && (vc_id_i == VCW'(v))) begin
          case (state[v])
            IDLE, LAST: begin
              if (head_i) begin
                state[v]         <= tail_i ? LAST : ROUTED;
                out_port_o[v]    <= route_l;
                route_valid_o[v] <= 1'b1;
`ifdef RC_DEST_CHECK_EN
                dest_err_o       <= dest_oor;
`endif
              end else begin
                proto_err_o <= 1'b1;
              end
            end
            ROUTED: begin
              if (head_i)      proto_err_o <= 1'b1;
              else if (tail_i) state[v]    <= LAST;
            end
            default: begin
              state[v]         <= IDLE;
              route_valid_o[v] <= 1'b0;
            end
          endcase
        end else if (state[v] == LAST) begin
          // Route is kept on the port so downstream sees a stable value after the tail.
          state[v]         <= IDLE;
          route_valid_o[v] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/rc_vc_stage.md
Name: rc_vc_stage

Overview:
Registered, per-virtual-channel route computation stage for one router input port in the 2D-mesh NoC. It computes the output port of a packet from the head flit's destination using dimension-order routing, either XY or YX, selected by parameter. It holds that route for every subsequent flit of the packet on the same VC until the tail has passed. It sits between the input buffer write side and VC allocation, and supplies `port_t` routes per VC.

Parameters:
- X_CURRENT, 0, X coordinate of this router (X grows left to right).
- Y_CURRENT, 0, Y coordinate of this router (Y grows top to bottom).
- DEST_ADDR_SIZE_X, 4, width of the X destination field.
- DEST_ADDR_SIZE_Y, 4, width of the Y destination field.
- VC_NUM, 2, number of virtual channels; must be at least 2.
- ROUTING_MODE, 0, 0 = XY (resolve X first), 1 = YX (resolve Y first).
- MESH_SIZE_X, 4, mesh columns; used only by the optional feature.
- MESH_SIZE_Y, 4, mesh rows; used only by the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  a flit is presented this cycle.
- vc_id_i  in  $clog2(VC_NUM)  VC of the presented flit.
- head_i  in  1  flit is a head.
- tail_i  in  1  flit is a tail; head_i=tail_i=1 means a single-flit packet.
- x_dest_i  in  DEST_ADDR_SIZE_X  destination X; sampled on head flits only.
- y_dest_i  in  DEST_ADDR_SIZE_Y  destination Y; sampled on head flits only.
- out_port_o  out  VC_NUM x port_t  registered route per VC.
- route_valid_o  out  VC_NUM  route for that VC is valid.
- proto_err_o  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset: every VC goes to IDLE, out_port_o[v]=LOCAL, route_valid_o=0, proto_err_o=0. Reset is asynchronous and overrides any packet in flight.
- Offset arithmetic: dx = {1'b0,x_dest_i} - X_CURRENT and dy = {1'b0,y_dest_i} - Y_CURRENT, both signed and one bit wider than the field.
- XY mode: dx<0 → WEST; dx>0 → EAST; dx=0 and dy<0 → NORTH; dx=0 and dy>0 → SOUTH; else LOCAL.
- YX mode: dy<0 → NORTH; dy>0 → SOUTH; dy=0 and dx<0 → WEST; dy=0 and dx>0 → EAST; else LOCAL.
- Per-VC FSM with states IDLE, ROUTED, LAST. Only the VC equal to vc_id_i is affected by a flit; all other VCs hold their state.
  - IDLE, head and not tail → ROUTED; route is latched.
  - IDLE, head and tail → LAST; route is latched.
  - ROUTED, non-head tail → LAST; route is held.
  - ROUTED, body flit or no flit → stays ROUTED.
  - LAST, no flit for this VC → IDLE; out_port_o keeps its last value, route_valid_o deasserts.
  - LAST, head flit → ROUTED or LAST per tail_i, with the new route latched. This allows back-to-back packets.
- route_valid_o[v] = 1 in ROUTED and LAST.
- Latency: route and route_valid_o appear exactly 1 cycle after the head flit is sampled.
- Violations: each of the following leaves the VC state and route unchanged and pulses proto_err_o for 1 cycle, registered.
  - head flit on a VC in ROUTED.
  - non-head flit on a VC in IDLE.
  - non-head flit on a VC in LAST.
  - vc_id_i >= VC_NUM (possible when VC_NUM is not a power of 2).
- valid_i=0: no state change anywhere; head_i, tail_i and the destination inputs are don't-care.

Optional Feature:
- Macro: RC_DEST_CHECK_EN.
- Defined:
  - Adds output port dest_err_o (1 bit, registered, reset 0).
  - A head flit with x_dest_i >= MESH_SIZE_X or y_dest_i >= MESH_SIZE_Y is still accepted; the FSM advances normally.
  - Its route is forced to LOCAL, and dest_err_o pulses 1 cycle, aligned with route_valid_o rising.
- Undefined: the dest_err_o port is absent and out-of-range destinations are routed by plain offset arithmetic.

Test Plan:
1. XY mode, router at (1,1), VC0 head to (3,0) → 1 cycle later out_port_o[0]=EAST, route_valid_o[0]=1. YX mode, same stimulus → NORTH.
2. VC1 carries head (dest (1,1)), body, body, tail on consecutive cycles → LOCAL valid from cycle 1 through the cycle after the tail, then route_valid_o[1]=0.
3. Interleave VC0 head to (0,1) (WEST) with VC1 head to (1,3) (SOUTH), then a VC0 tail → VC1 route unchanged, VC0 goes LAST then IDLE.
4. Back-to-back single-flit packets on VC0 to (2,1) then (1,0) → EAST for one cycle, then NORTH, with route_valid_o[0] held at 1 across both.
5. Body flit on IDLE VC0; second head on ROUTED VC1 → proto_err_o pulses each time, states and routes unchanged.
6. Assert rst mid-packet on VC0 → immediate IDLE, LOCAL, route_valid_o=0. With RC_DEST_CHECK_EN and a 4x4 mesh, head to (5,2) → LOCAL plus a dest_err_o pulse.
